// File: rtl/inst_decode_stage.sv
// Registered instruction decode stage with a 2-entry output/skid buffer.
// Optional illegal-instruction flag enabled by defining DEC_ILLEGAL_EN.
module inst_decode_stage #(
   parameter int         XLEN   = 32,
   parameter logic [5:0] R_OP   = 6'h00,
   parameter logic [5:0] J_OP   = 6'h02,
   parameter logic [5:0] JAL_OP = 6'h03
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     inst,
   input  logic [XLEN-1:0] pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [5:0]      op,
   output logic [5:0]      funct,
   output logic [4:0]      rd,
   output logic [4:0]      rt,
   output logic [4:0]      rs,
   output logic [4:0]      shamt,
   output logic [XLEN-1:0] imm_ext,
   output logic [XLEN-1:0] j_target,
   output logic [1:0]      itype,
   output logic [XLEN-1:0] out_pc
`ifdef DEC_ILLEGAL_EN
   ,
   output logic            illegal
`endif
);

   localparam logic [1:0] ITYPE_R = 2'd0;
   localparam logic [1:0] ITYPE_I = 2'd1;
   localparam logic [1:0] ITYPE_J = 2'd2;

   typedef struct packed {
      logic [5:0]      op;
      logic [5:0]      funct;
      logic [4:0]      rd;
      logic [4:0]      rt;
      logic [4:0]      rs;
      logic [4:0]      shamt;
      logic [XLEN-1:0] imm_ext;
      logic [XLEN-1:0] j_target;
      logic [XLEN-1:0] pc;
      logic [1:0]      itype;
`ifdef DEC_ILLEGAL_EN
      logic            illegal;
`endif
   } entry_t;

   entry_t           dec;
   entry_t           out_q;
   entry_t           skid_q;
   logic             skid_valid;
   logic             in_fire;
   logic [XLEN-29:0] pc4_hi;

`ifdef DEC_ILLEGAL_EN
   function automatic logic is_illegal(input logic [5:0] o, input logic [5:0] f);
      logic legal;
      legal = 1'b0;
      if (o == R_OP)
         legal = (f == 6'h00) || (f == 6'h02) || (f == 6'h08) ||
                 ((f >= 6'h20) && (f <= 6'h2A));
      else if ((o == J_OP) || (o == JAL_OP) || ((o >= 6'h04) && (o <= 6'h0F)) ||
               (o == 6'h23) || (o == 6'h2B))
         legal = 1'b1;
      return !legal;
   endfunction
`endif

   // Upper bits of pc+4: bits [27:0] are replaced by the jump field, so only
   // the carry out of bit 27 matters.
   assign pc4_hi  = pc[XLEN-1:28] + {{(XLEN-29){1'b0}}, &pc[27:2]};
   assign in_fire = in_valid & in_ready;

   // NOTE: combinational blocks use blocking assignments and assign every
   // output first, so no latch can be inferred.
   always_comb begin
      dec          = '0;
      dec.op       = inst[31:26];
      dec.rd       = inst[25:21];
      dec.rt       = inst[20:16];
      dec.rs       = inst[15:11];
      dec.shamt    = inst[10:6];
      dec.funct    = inst[5:0];
      dec.pc       = pc;
      dec.j_target = {pc4_hi, inst[25:0], 2'b00};
      if ((dec.op == 6'h0C) || (dec.op == 6'h0D) || (dec.op == 6'h0E))
         dec.imm_ext = {{(XLEN-16){1'b0}}, inst[15:0]};
      else
         dec.imm_ext = {{(XLEN-16){inst[15]}}, inst[15:0]};
      if (dec.op == R_OP)
         dec.itype = ITYPE_R;
      else if ((dec.op == J_OP) || (dec.op == JAL_OP))
         dec.itype = ITYPE_J;
      else
         dec.itype = ITYPE_I;
`ifdef DEC_ILLEGAL_EN
      dec.illegal = is_illegal(inst[31:26], inst[5:0]);
`endif
   end

   // Output slot is free when empty or draining this cycle; skid entry has
   // priority over new input to keep order. in_ready never sees out_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
         out_q      <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else if (!out_valid || out_ready) begin
         if (skid_valid) begin
            out_q      <= skid_q;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
         end else if (in_fire) begin
            out_q     <= dec;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (in_fire) begin
         skid_valid <= 1'b1;
         in_ready   <= 1'b0;
      end
   end

   // NOTE: skid data needs no reset; it is only read while skid_valid is set,
   // and skid_valid is reset.
   always_ff @(posedge clk) begin
      if (in_fire)
         skid_q <= dec;
   end

   assign op       = out_q.op;
   assign funct    = out_q.funct;
   assign rd       = out_q.rd;
   assign rt       = out_q.rt;
   assign rs       = out_q.rs;
   assign shamt    = out_q.shamt;
   assign imm_ext  = out_q.imm_ext;
   assign j_target = out_q.j_target;
   assign itype    = out_q.itype;
   assign out_pc   = out_q.pc;
`ifdef DEC_ILLEGAL_EN
   assign illegal  = out_q.illegal;
`endif

endmodule

// File: tb/tb_inst_decode_stage.sv
// Scoreboard bench for inst_decode_stage: driver pushes expected entries from
// a reference decode model, monitor pops and compares on every valid cycle.
module tb_inst_decode_stage;

   typedef struct packed {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic [4:0]  rd;
      logic [4:0]  rt;
      logic [4:0]  rs;
      logic [4:0]  shamt;
      logic [31:0] imm_ext;
      logic [31:0] j_target;
      logic [31:0] pc;
      logic [1:0]  itype;
      logic        illegal;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] drv_inst, drv_pc;
   logic [5:0]  op, funct;
   logic [4:0]  rd, rt, rs, shamt;
   logic [31:0] imm_ext, j_target, out_pc;
   logic [1:0]  itype;
   logic        illegal_w;

   int   total = 0;
   int   bad   = 0;
   exp_t sb_q[$];
   logic force_en  = 1'b1;
   logic force_val = 1'b1;

   always #5 clk = ~clk;

   inst_decode_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .inst(drv_inst), .pc(drv_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .op(op), .funct(funct), .rd(rd), .rt(rt), .rs(rs), .shamt(shamt),
      .imm_ext(imm_ext), .j_target(j_target), .itype(itype), .out_pc(out_pc)
`ifdef DEC_ILLEGAL_EN
      , .illegal(illegal_w)
`endif
   );

`ifndef DEC_ILLEGAL_EN
   assign illegal_w = 1'b0;
`endif

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode straight from the field map and extension rules.
   function automatic exp_t model(input logic [31:0] w, input logic [31:0] p);
      exp_t e;
      int   o, f;
      e.op = w[31:26]; e.rd = w[25:21]; e.rt = w[20:16];
      e.rs = w[15:11]; e.shamt = w[10:6]; e.funct = w[5:0];
      e.pc = p;
      o = int'(w[31:26]);
      f = int'(w[5:0]);
      if (o == 12 || o == 13 || o == 14) e.imm_ext = 32'(w[15:0]);
      else                               e.imm_ext = 32'(int'($signed(w[15:0])));
      e.j_target = ((p + 32'd4) & 32'hF000_0000) | (32'(w[25:0]) * 4);
      e.itype = (o == 0) ? 2'd0 : (o == 2 || o == 3) ? 2'd2 : 2'd1;
      e.illegal = 1'b0;
`ifdef DEC_ILLEGAL_EN
      if (o == 0) e.illegal = !(f == 0 || f == 2 || f == 8 || (f >= 32 && f <= 42));
      else        e.illegal = !(o == 2 || o == 3 || (o >= 4 && o <= 15) || o == 35 || o == 43);
`endif
      return e;
   endfunction

   // Offer one instruction; it is accepted at the next posedge when in_ready is high.
   task automatic drive_one(input logic [31:0] w, input logic [31:0] p);
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         #1;
         in_valid = 1'b1; drv_inst = w; drv_pc = p;
         if (in_ready) begin
            sb_q.push_back(model(w, p));
            return;
         end
      end
      check("accept_timeout", 1, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         #1 in_valid = 1'b0;
      end
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 4))
         0: w[31:26] = 6'h00;
         1: w[31:26] = 6'(12 + $urandom_range(0, 2));
         2: w[31:26] = 6'(2 + $urandom_range(0, 1));
         default: ;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] rand_pc();
      logic [31:0] p;
      p = $urandom;
      if ($urandom_range(0, 7) == 0) p = 32'hFFFF_FFF0 | (p & 32'hC);
      else if ($urandom_range(0, 7) == 0) p = (p & 32'hF000_0000) | 32'h0FFF_FFFC;
      return p;
   endfunction

   // Monitor: compare the presented entry every valid cycle (which also proves
   // stability while stalled), pop when this cycle's ready makes it fire.
   initial begin
      exp_t a;
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         out_ready = force_en ? force_val : ($urandom_range(0, 9) < 6);
         if (out_valid) begin
            a.op = op; a.funct = funct; a.rd = rd; a.rt = rt; a.rs = rs;
            a.shamt = shamt; a.imm_ext = imm_ext; a.j_target = j_target;
            a.pc = out_pc; a.itype = itype; a.illegal = illegal_w;
            if (sb_q.size() == 0) begin
               check("unexpected_out", a, 0);
            end else begin
               check("out", a, sb_q[0]);
               if (out_ready) void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; drv_inst = '0; drv_pc = '0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_fields", {op, funct, rd, rt, rs, shamt, itype}, 0);
      check("rst_imm_jt_pc", {imm_ext, j_target, out_pc}, 0);
      #1 rst = 1'b0;

      drive_one(32'h2108FFFC, 32'h0);
      @(negedge clk);
      check("lat_out_valid", out_valid, 1);
      check("addi_imm", imm_ext, 32'hFFFFFFFC);
      check("addi_itype", itype, 1);
      check("addi_rd_rt", {rd, rt}, {5'd8, 5'd8});
      #1 in_valid = 1'b0;
      drive_one(32'h3508FFFF, 32'h4);
      @(negedge clk);
      check("ori_imm", imm_ext, 32'h0000FFFF);
      #1 in_valid = 1'b0;
      drive_one(32'h08000010, 32'hF0000000);
      @(negedge clk);
      check("j_itype", itype, 2);
      check("j_target", j_target, 32'hF0000040);
      #1 in_valid = 1'b0;
      idle(2);

      // Stall: two captured, third held off until the stall releases.
      force_val = 1'b0;
      drive_one(32'h012A4020, 32'h100);
      drive_one(32'h8D090004, 32'h104);
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_hold_pc", out_pc, 32'h100);
      #1 force_val = 1'b1;
      drive_one(32'h0C000123, 32'h108);
      idle(4);

      // Flush with full buffer and a simultaneous offer.
      force_val = 1'b0;
      drive_one(32'h20420001, 32'h200);
      drive_one(32'h20630002, 32'h204);
      @(negedge clk);
      #1 flush = 1'b1; in_valid = 1'b1; drv_inst = 32'h20840003; drv_pc = 32'h208;
      sb_q.delete();
      @(negedge clk);
      check("flush_out_valid", out_valid, 0);
      check("flush_in_ready", in_ready, 1);
      #1 flush = 1'b0; in_valid = 1'b0; force_val = 1'b1;
      idle(3);
      @(negedge clk);
      check("flush_no_output", out_valid, 0);

      // Reset mid-transfer wins over flush and in_valid.
      force_val = 1'b0;
      drive_one(32'h24A5FFFF, 32'h300);
      drive_one(32'h24C60001, 32'h304);
      @(negedge clk);
      #1 rst = 1'b1; flush = 1'b1; in_valid = 1'b1; drv_inst = 32'h24E70002; drv_pc = 32'h308;
      sb_q.delete();
      @(negedge clk);
      check("rst2_out_valid", out_valid, 0);
      check("rst2_in_ready", in_ready, 1);
      check("rst2_data", {imm_ext, out_pc, itype}, 0);
      #1 rst = 1'b0; flush = 1'b0; in_valid = 1'b0; force_val = 1'b1;
      idle(2);

`ifdef DEC_ILLEGAL_EN
      drive_one(32'hFC000000, 32'h400);
      drive_one(32'h0000003F, 32'h404);
      drive_one(32'h00000020, 32'h408);
      idle(4);
`endif

      force_en = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         drive_one(rand_inst(), rand_pc());
      end
      idle(1);
      force_en = 1'b1; force_val = 1'b1;
      n = 0;
      while ((sb_q.size() != 0 || out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", sb_q.size(), 0);
      check("drain_out_valid", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_decode_stage.md
INST_DECODE_STAGE -- requirements
Module: inst_decode_stage

Interface
REQ-001 Parameter XLEN, default 32: width of PC, extended immediate and jump target; legal values 32 and 64.
REQ-002 Parameter R_OP, default 6'h00: opcode of R-type instructions.
REQ-003 Parameter J_OP, default 6'h02, and JAL_OP, default 6'h03: opcodes of J-type instructions.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1 / in_ready  out  1: upstream handshake; transfer when both are high.
REQ-007 inst  in  32  instruction word; pc  in  XLEN  address of inst.
REQ-008 flush  in  1  discard all buffered instructions.
REQ-009 out_valid  out  1 / out_ready  in  1: downstream handshake.
REQ-010 op, funct  out  6 each; rd, rt, rs, shamt  out  5 each: registered fields.
REQ-011 imm_ext  out  XLEN; j_target  out  XLEN; itype  out  2 (0=R, 1=I, 2=J, 3 unused); out_pc  out  XLEN.
REQ-012 illegal  out  1: present only when DEC_ILLEGAL_EN is defined.

Function
REQ-013 Field map: op=inst[31:26], rd=inst[25:21], rt=inst[20:16], rs=inst[15:11], shamt=inst[10:6], funct=inst[5:0], imm=inst[15:0], j_add=inst[25:0].
REQ-014 imm_ext zero-extends imm when op is 6'h0C, 6'h0D or 6'h0E; otherwise sign-extends imm[15].
REQ-015 j_target = {(pc+4)[XLEN-1:28], j_add, 2'b00}; pc+4 wraps modulo 2^XLEN.
REQ-016 itype = 0 when op==R_OP, 2 when op==J_OP or JAL_OP, else 1.
REQ-017 Decode is registered: latency exactly 1 cycle from accepted input to out_valid with an empty buffer.
REQ-018 Buffering: a 2-entry store (output register plus skid register), order preserved, no bubble at full throughput.
REQ-019 in_ready is a registered output, high iff the skid register is empty; it never combinationally depends on out_ready.
REQ-020 Once out_valid is high, all outputs hold stable until out_ready is sampled high.
REQ-021 Output fire with skid full: skid moves into the output register in the same cycle; in_ready rises the next cycle.
REQ-022 Input fire while output holds a stalled entry: the new entry goes into skid; in_ready falls the next cycle.
REQ-023 Simultaneous input fire and output fire, skid empty: the new entry replaces the output entry; out_valid stays high.
REQ-024 flush: both entries invalid next cycle (out_valid=0, in_ready=1); in_valid in the flush cycle is ignored; flush overrides every other event.
REQ-025 Invalid-cycle data outputs hold their last value and carry no meaning.

Reset
REQ-026 On rst high at a clock edge: out_valid=0, in_ready=1, skid empty, all field outputs, imm_ext, j_target, out_pc = 0, itype=0, illegal=0.
REQ-027 rst mid-transfer discards both entries; rst overrides flush and in_valid in the same cycle.

Configuration
REQ-028 Macro DEC_ILLEGAL_EN defined: illegal=1 for an entry whose op is not R_OP, J_OP, JAL_OP, 6'h04-6'h0F, 6'h23 or 6'h2B, or whose op==R_OP with funct outside {6'h00,6'h02,6'h08,6'h20-6'h2A}; illegal travels with its entry.
REQ-029 Macro undefined: no illegal port and no illegal logic; all other behaviour is identical.

Verification
REQ-030 Reset, then inst=32'h2108FFFC (op 08), pc=0, out_ready=1 -> 1 cycle later out_valid=1, itype=1, imm_ext=32'hFFFFFFFC, rd=8, rt=8.
REQ-031 inst=32'h3508FFFF (ori) -> imm_ext=32'h0000FFFF; inst=32'h08000010, pc=32'hF0000000 -> itype=2, j_target=32'hF0000040.
REQ-032 out_ready=0, three back-to-back in_valid -> first two captured, in_ready=0 from the third cycle, then out_ready=1 -> outputs in order with no drop or duplicate.
REQ-033 Buffer full, flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, the offered instruction is not output.
REQ-034 Random valid/ready stall pattern over 10,000 instructions -> output sequence equals input sequence, outputs stable while stalled.
REQ-035 DEC_ILLEGAL_EN defined, inst op=6'h3F -> illegal=1; R-type funct=6'h3F -> illegal=1; inst=32'h00000020 -> illegal=0.
